// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE
  } sar_state_t;

  localparam int SAR_WIDTH = 10;
  localparam logic [SAR_WIDTH-1:0] SAR_MIDSCALE = 10'h200;

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Conversion request/result bundle between the SAR controller and its user.
// Handshake: start is a level request that is accepted on a clock edge only
// while busy is low; sample_valid is a one-cycle pulse with no back-pressure.
interface sar_adc_ctrl_if
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
);
  logic             start;
  logic             comp;
  logic [WIDTH-1:0] dac_out;
  logic             busy;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  sar_state_t       state;

  modport master (
    output start, comp,
    input  dac_out, busy, sample, sample_valid, state
  );

  modport slave (
    input  start, comp,
    output dac_out, busy, sample, sample_valid, state
  );
endinterface

// File: rtl/comp_sync.sv
// Multi-flop synchronizer bringing the asynchronous comparator into clk.
module comp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic comp,
  output logic cs
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], comp};
    end
  end

  assign cs = sync_q[STAGES-1];
endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: binary search over the DAC bits using the synchronized
// comparator, one bit per SETTLE+DECIDE period.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input logic           clk,
  input logic           rst_n,
  sar_adc_ctrl_if.slave bus
);
  localparam int WAIT_MAX = SETTLE_CYCLES + SYNC_STAGES - 1;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);
  localparam logic [3:0]        MSB_IDX   = 4'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0]  MIDSCALE  = ONE << (WIDTH - 1);

  sar_state_t        state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WIDTH-1:0]  dac_q, dac_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  sample_q, sample_d;
  logic              valid_q, valid_d;

  logic              cs;
  logic [WIDTH-1:0]  bit_mask;
  logic [WIDTH-1:0]  next_mask;
  logic [WIDTH-1:0]  bit_val;

  comp_sync #(
    .STAGES(SYNC_STAGES)
  ) u_comp_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .comp (bus.comp),
    .cs   (cs)
  );

  // Current trial bit kept when the input is at or above the DAC voltage.
  assign bit_mask  = ONE << bit_idx_q;
  assign next_mask = ONE << (bit_idx_q - 4'd1);
  assign bit_val   = cs ? (result_q | bit_mask) : result_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    bit_idx_d = bit_idx_q;
    wait_d    = wait_q;
    dac_d     = dac_q;
    busy_d    = busy_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        dac_d  = MIDSCALE;
        busy_d = 1'b0;
        if (bus.start) begin
          result_d  = '0;
          bit_idx_d = MSB_IDX;
          wait_d    = '0;
          busy_d    = 1'b1;
          state_d   = SETTLE;
        end
      end

      SETTLE: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = DECIDE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      DECIDE: begin
        result_d = bit_val;
        if (bit_idx_q != 4'd0) begin
          dac_d     = bit_val | next_mask;
          bit_idx_d = bit_idx_q - 4'd1;
          wait_d    = '0;
          state_d   = SETTLE;
        end else begin
          sample_d = bit_val;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          dac_d    = MIDSCALE;
          state_d  = IDLE;
        end
      end

      default: begin
        dac_d   = MIDSCALE;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      bit_idx_q <= '0;
      wait_q    <= '0;
      dac_q     <= MIDSCALE;
      busy_q    <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      bit_idx_q <= bit_idx_d;
      wait_q    <= wait_d;
      dac_q     <= dac_d;
      busy_q    <= busy_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.dac_out      = dac_q;
  assign bus.busy         = busy_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.state        = state_q;
endmodule
